// File: rtl/alu_mdu.sv
// alu_mdu: RV64I/RV32I execute unit. It contains a single-cycle base/word ALU and an
// iterative M extension (shift-add multiply, restoring divide), with valid/ready on both sides.
module alu_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            op_w,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int PW = 2 * XLEN;
    localparam logic [CW-1:0]   LAST_X = CW'(XLEN - 1);
    localparam logic [CW-1:0]   LAST_W = CW'(31);
    localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic signed [31:0] s;
        s = $signed(x);
        return XLEN'(s);
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
        return XLEN'(x);
    endfunction

    function automatic logic [XLEN-1:0] base_alu(
        input logic [XLEN-1:0] x,
        input logic [XLEN-1:0] y,
        input logic [2:0]      f3,
        input logic            alt,
        input logic            w
    );
        logic [XLEN-1:0]        r;
        logic [31:0]            r32;
        logic signed [XLEN-1:0] xs;
        logic signed [31:0]     xs32;
        logic [5:0]             sh;
        r    = '0;
        r32  = '0;
        xs   = $signed(x);
        xs32 = $signed(x[31:0]);
        sh   = (XLEN == 64 && !w) ? y[5:0] : {1'b0, y[4:0]};
        if (w) begin
            case (f3)
                3'b000:  r32 = alt ? x[31:0] - y[31:0] : x[31:0] + y[31:0];
                3'b001:  r32 = x[31:0] << y[4:0];
                3'b101: begin
                    xs32 = xs32 >>> y[4:0];
                    r32  = alt ? xs32 : x[31:0] >> y[4:0];
                end
                default: r32 = '0;
            endcase
            r = sext32(r32);
        end else begin
            case (f3)
                3'b000:  r = alt ? x - y : x + y;
                3'b001:  r = x << sh;
                3'b010:  r[0] = xs < $signed(y);
                3'b011:  r[0] = x < y;
                3'b100:  r = x ^ y;
                3'b101: begin
                    xs = xs >>> sh;
                    r  = alt ? xs : x >> sh;
                end
                3'b110:  r = x | y;
                default: r = x & y;
            endcase
        end
        return r;
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [PW-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic            w_q, w_d, hi_q, hi_d, neg_q, neg_d, rneg_q, rneg_d, remop_q, remop_d;

    logic            accept, is_m, alt, w_op, op_sa, op_sb, a_neg, b_neg;
    logic            div_zero, div_ovf, last;
    logic [XLEN-1:0] a_op, b_op, a_mag, b_mag, a_res;
    logic [PW-1:0]   acc_n, prod;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] rem_n, quo_n, q_fix, r_fix, div_sel, mul_res, div_res;

    assign in_ready = !flush && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign is_m     = funct7 == 7'b0000001;
    assign alt      = funct7 == 7'b0100000;
    assign w_op     = (XLEN == 64) && op_w;

    // Multiply signedness comes from funct3. Divides are signed unless funct3[0] is set.
    // MULW returns only the low word, so its operands are always treated as unsigned.
    always_comb begin
        op_sa = 1'b0;
        op_sb = 1'b0;
        if (funct3[2]) begin
            op_sa = !funct3[0];
            op_sb = !funct3[0];
        end else if (!w_op) begin
            op_sa = funct3 == 3'b001 || funct3 == 3'b010;
            op_sb = funct3 == 3'b001;
        end
    end

    assign a_op     = w_op ? (op_sa ? sext32(a[31:0]) : zext32(a[31:0])) : a;
    assign b_op     = w_op ? (op_sb ? sext32(b[31:0]) : zext32(b[31:0])) : b;
    assign a_neg    = op_sa && a_op[XLEN-1];
    assign b_neg    = op_sb && b_op[XLEN-1];
    assign a_mag    = a_neg ? -a_op : a_op;
    assign b_mag    = b_neg ? -b_op : b_op;
    assign a_res    = w_op ? sext32(a[31:0]) : a;
    assign div_zero = b_op == '0;
    assign div_ovf  = op_sa && (b_op == '1) && (w_op ? a[31:0] == 32'h8000_0000 : a == MIN_X);

    assign acc_n   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod    = neg_q ? -acc_n : acc_n;
    assign mul_res = w_q ? sext32(prod[31:0]) : (hi_q ? prod[PW-1:XLEN] : prod[XLEN-1:0]);

    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvs_q};
    assign rem_n   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_n   = {quo_q[XLEN-2:0], !diff[XLEN]};
    assign q_fix   = neg_q ? -quo_n : quo_n;
    assign r_fix   = rneg_q ? -rem_n : rem_n;
    assign div_sel = remop_q ? r_fix : q_fix;
    assign div_res = w_q ? sext32(div_sel[31:0]) : div_sel;

    assign last    = cnt_q == (w_q ? LAST_W : LAST_X);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        w_d      = w_q;
        hi_d     = hi_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        remop_d  = remop_q;

        case (state_q)
            S_MUL: begin
                acc_d    = acc_n;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    result_d = mul_res;
                    state_d  = S_DONE;
                    cnt_d    = '0;
                end
            end
            S_DIV: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                    cnt_d    = '0;
                end
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: ;
        endcase

        // An accept in DONE overrides the return to IDLE, which keeps back-to-back ops seamless.
        if (accept) begin
            w_d   = w_op;
            cnt_d = '0;
            if (!is_m) begin
                result_d = base_alu(a, b, funct3, alt, w_op);
                state_d  = S_DONE;
            end else if (!funct3[2]) begin
                if (w_op && funct3 != 3'b000) begin
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    acc_d    = '0;
                    mcand_d  = PW'(a_mag);
                    mplier_d = b_mag;
                    neg_d    = a_neg ^ b_neg;
                    hi_d     = funct3 != 3'b000;
                    state_d  = S_MUL;
                end
            end else if (div_zero) begin
                result_d = funct3[1] ? a_res : '1;
                state_d  = S_DONE;
            end else if (div_ovf) begin
                result_d = funct3[1] ? '0 : a_res;
                state_d  = S_DONE;
            end else begin
                // Word dividends are pre-aligned to the top so 32 iterations consume them fully.
                rem_d   = '0;
                quo_d   = w_op ? (a_mag << (XLEN - 32)) : a_mag;
                dvs_d   = b_mag;
                neg_d   = a_neg ^ b_neg;
                rneg_d  = a_neg;
                remop_d = funct3[1];
                state_d = S_DIV;
            end
        end

        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    assign out_valid_d = state_d == S_DONE;
    assign busy_d      = state_d == S_MUL || state_d == S_DIV;
    assign zero_d      = result_d == '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Engine working registers are only meaningful while the FSM says so, hence no reset.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        dvs_q    <= dvs_d;
        w_q      <= w_d;
        hi_q     <= hi_d;
        neg_q    <= neg_d;
        rneg_q   <= rneg_d;
        remop_q  <= remop_d;
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed bench for alu_mdu. Expected results are queued when an operation
// is driven and popped when out_valid appears.
module tb_alu_mdu;
    localparam int XLEN = 64;
    localparam logic [6:0] F7_B = 7'b0000000;
    localparam logic [6:0] F7_A = 7'b0100000;
    localparam logic [6:0] F7_M = 7'b0000001;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, op_w, out_ready;
    logic [XLEN-1:0] a, b;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            in_ready, out_valid, zero, busy;
    logic [XLEN-1:0] result;

    int              checks = 0;
    int              errors = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] last_exp = '0;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .funct3(funct3), .funct7(funct7), .op_w(op_w),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f3, input logic [6:0] f7, input logic w,
                         input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        funct3 = f3; funct7 = f7; op_w = w; a = x; b = y;
        in_valid = 1'b1;
    endtask

    task automatic take(input string tag);
        logic [XLEN-1:0] e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        last_exp = e;
        check({tag, " out_valid"}, XLEN'(out_valid), XLEN'(1));
        check(tag, result, e);
        check({tag, " zero"}, XLEN'(zero), XLEN'(e == '0));
    endtask

    task automatic issue(input logic [2:0] f3, input logic [6:0] f7, input logic w,
                         input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                         input logic [XLEN-1:0] e);
        check("in_ready before issue", XLEN'(in_ready), XLEN'(1));
        drive(f3, f7, w, x, y);
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat, output int busy_cyc);
        int lat;
        lat = 1;
        busy_cyc = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, XLEN'(lat), XLEN'(exp_lat));
        take(tag);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                          input logic w, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                          input logic [XLEN-1:0] e, input int lat);
        int bc;
        issue(f3, f7, w, x, y, e);
        wait_result(tag, lat, bc);
        @(negedge clk);
    endtask

    initial begin
        int bc;
        int seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op_w = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; funct3 = '0; funct7 = '0;
        repeat (3) @(negedge clk);
        check("reset result", result, '0);
        check("reset zero", XLEN'(zero), XLEN'(1));
        check("reset out_valid", XLEN'(out_valid), XLEN'(0));
        check("reset busy", XLEN'(busy), XLEN'(0));
        check("reset in_ready", XLEN'(in_ready), XLEN'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 5 + -5
        issue(3'b000, F7_B, 1'b0, 64'd5, -64'sd5, 64'd0);
        wait_result("ADD", 1, bc);
        check("ADD in_ready after", XLEN'(in_ready), XLEN'(1));
        @(negedge clk);

        // Back-to-back SUB, SRA, SLTU
        drive(3'b000, F7_A, 1'b0, 64'd3, 64'd5);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        check("b2b in_ready SRA", XLEN'(in_ready), XLEN'(1));
        take("SUB");
        drive(3'b101, F7_A, 1'b0, 64'h8000_0000_0000_0000, 64'd4);
        exp_q.push_back(64'hF800_0000_0000_0000);
        @(negedge clk);
        check("b2b in_ready SLTU", XLEN'(in_ready), XLEN'(1));
        take("SRA");
        drive(3'b011, F7_B, 1'b0, 64'd1, 64'd2);
        exp_q.push_back(64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        take("SLTU");
        @(negedge clk);

        // Shift amount masking, word ops, SLT
        run_op("SRL b=0xFF", 3'b101, F7_B, 1'b0, '1, 64'hFF, 64'd1, 1);
        run_op("SLLW b=0x3F", 3'b001, F7_B, 1'b1, 64'd1, 64'h3F, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("SRAW", 3'b101, F7_A, 1'b1, 64'h0000_0000_8000_0000, 64'd4,
               64'hFFFF_FFFF_F800_0000, 1);
        run_op("XOR W no-form", 3'b100, F7_B, 1'b1, 64'd5, 64'd3, 64'd0, 1);
        run_op("SLT", 3'b010, F7_B, 1'b0, '1, 64'd1, 64'd1, 1);

        // MULHU all ones
        issue(3'b011, F7_M, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
        wait_result("MULHU", 65, bc);
        check("MULHU busy cycles", XLEN'(bc), XLEN'(64));
        @(negedge clk);
        run_op("MUL", 3'b000, F7_M, 1'b0, -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 65);
        run_op("MULH", 3'b001, F7_M, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
               64'h3FFF_FFFF_FFFF_FFFF, 65);
        run_op("MULHSU", 3'b010, F7_M, 1'b0, '1, 64'd4, '1, 65);
        run_op("MULW", 3'b000, F7_M, 1'b1, 64'hDEAD_0000_7FFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 33);

        // Divide family and special cases
        run_op("DIV ovf", 3'b100, F7_M, 1'b0, 64'h8000_0000_0000_0000, '1,
               64'h8000_0000_0000_0000, 1);
        run_op("DIVU by 0", 3'b101, F7_M, 1'b0, 64'd12345, 64'd0, '1, 1);
        run_op("REMW", 3'b110, F7_M, 1'b1, -64'sd7, 64'd2, '1, 33);
        run_op("DIV", 3'b100, F7_M, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("REM", 3'b110, F7_M, 1'b0, 64'd7, -64'sd2, 64'd1, 65);
        run_op("DIVU", 3'b101, F7_M, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run_op("REMU", 3'b111, F7_M, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        run_op("REMUW by 0", 3'b111, F7_M, 1'b1, 64'h1234_5678_8000_0005, 64'hFFFF_FFFF_0000_0000,
               64'hFFFF_FFFF_8000_0005, 1);
        run_op("DIVW ovf", 3'b100, F7_M, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1);

        // ADDW with backpressure
        out_ready = 1'b0;
        issue(3'b000, F7_B, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
        wait_result("ADDW", 1, bc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp result", result, 64'hFFFF_FFFF_8000_0000);
            check("bp out_valid", XLEN'(out_valid), XLEN'(1));
            check("bp in_ready", XLEN'(in_ready), XLEN'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp released out_valid", XLEN'(out_valid), XLEN'(0));

        // Flush during DIV iteration 20
        check("in_ready before flushed DIV", XLEN'(in_ready), XLEN'(1));
        drive(3'b100, F7_M, 1'b0, 64'd1000, 64'd7);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("flush busy before", XLEN'(busy), XLEN'(1));
        flush = 1'b1;
        #1;
        check("flush in_ready", XLEN'(in_ready), XLEN'(0));
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush out_valid", XLEN'(out_valid), XLEN'(0));
        check("flush busy", XLEN'(busy), XLEN'(0));
        check("flush in_ready after", XLEN'(in_ready), XLEN'(1));
        check("flush result kept", result, last_exp);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("flush no late out_valid", XLEN'(seen), XLEN'(0));

        // flush together with in_valid: nothing accepted
        drive(3'b000, F7_B, 1'b0, 64'd1, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush+valid out_valid", XLEN'(out_valid), XLEN'(0));
        check("flush+valid result", result, last_exp);
        @(negedge clk);

        // flush while holding a result in DONE
        out_ready = 1'b0;
        issue(3'b000, F7_B, 1'b0, 64'd2, 64'd3, 64'd5);
        wait_result("ADD held", 1, bc);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        check("flush DONE out_valid", XLEN'(out_valid), XLEN'(0));
        check("flush DONE result kept", result, 64'd5);
        @(negedge clk);

        // Reset mid-iteration
        drive(3'b100, F7_M, 1'b0, 64'd1000, 64'd7);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst mid result", result, '0);
        check("rst mid zero", XLEN'(zero), XLEN'(1));
        check("rst mid out_valid", XLEN'(out_valid), XLEN'(0));
        check("rst mid busy", XLEN'(busy), XLEN'(0));
        check("rst mid in_ready", XLEN'(in_ready), XLEN'(1));
        rst_n = 1'b1;
        @(negedge clk);
        run_op("ADD after reset", 3'b000, F7_B, 1'b0, 64'd40, 64'd2, 64'd42, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
